// File: rtl/quadrature_encoder_emulator.sv
// quadrature_encoder_emulator
// Turns signed step-count / edge-period move commands into x4 incremental
// encoder A/B outputs. One step is one quadrature edge. The A/B phase and the
// position count persist across moves and are cleared only by rst.
module quadrature_encoder_emulator #(
    parameter int CNT_W = 32,
    parameter int PER_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic signed [CNT_W-1:0] cmd_steps,
    input  logic        [PER_W-1:0] cmd_period,
    input  logic                    abort,
    output logic                    A,
    output logic                    B,
    output logic                    edge_stb,
    output logic                    direction,
    output logic                    busy,
    output logic                    done,
    output logic signed [CNT_W-1:0] position
);

    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PER_W-1:0] ZERO_PER = {PER_W{1'b0}};
    localparam logic [PER_W-1:0] ONE_PER  = {{(PER_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic [PER_W-1:0] per_q,   per_d;
    logic [PER_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] pos_q,   pos_d;
    logic             a_q,     a_d;
    logic             b_q,     b_d;
    logic             edge_q,  edge_d;
    logic             dir_q,   dir_d;
    logic             done_q,  done_d;

    logic [CNT_W-1:0] steps_mag_s;
    logic [PER_W-1:0] per_eff_s;
    logic             emit_s;
    logic             emit_fwd_s;
    logic [1:0]       phase_next_s;

    // Next {A,B} one quadrature step away from ab.
    // Forward walks 00->10->11->01, reverse walks the same ring backwards,
    // so exactly one channel toggles per step.
    function automatic logic [1:0] next_phase(input logic [1:0] ab, input logic fwd);
        logic [1:0] nxt;
        if (fwd) begin
            nxt = {~ab[0], ab[1]};
        end else begin
            nxt = {ab[0], ~ab[1]};
        end
        return nxt;
    endfunction

    // Magnitude of the commanded step count; unsigned so the most negative value is exact.
    always_comb begin
        if (cmd_steps[CNT_W-1]) begin
            steps_mag_s = $unsigned(~cmd_steps) + ONE_CNT;
        end else begin
            steps_mag_s = $unsigned(cmd_steps);
        end
    end

    // A zero period would never produce an edge, so it runs at one clock per edge.
    always_comb begin
        if (cmd_period == ZERO_PER) begin
            per_eff_s = ONE_PER;
        end else begin
            per_eff_s = cmd_period;
        end
    end

    // Move sequencing: accept, edge timing, completion and abort.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        per_d      = per_q;
        timer_d    = timer_q;
        dir_d      = dir_q;
        done_d     = 1'b0;
        emit_s     = 1'b0;
        emit_fwd_s = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    dir_d = ~cmd_steps[CNT_W-1];
                    per_d = per_eff_s;
                    if (steps_mag_s == ZERO_CNT) begin
                        // Empty move: acknowledge with done, never leave IDLE.
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        if (per_eff_s == ONE_PER) begin
                            // First edge is due one cycle after accept, so emit it now.
                            emit_s     = 1'b1;
                            emit_fwd_s = ~cmd_steps[CNT_W-1];
                            rem_d      = steps_mag_s - ONE_CNT;
                            timer_d    = ONE_PER;
                        end else begin
                            // timer counts cycles left until the next edge decision.
                            rem_d   = steps_mag_s;
                            timer_d = per_eff_s - ONE_PER;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // Stop without further edges and without done.
                    state_d = ST_IDLE;
                end else if (rem_q == ZERO_CNT) begin
                    // Last edge is on the outputs this cycle; finish the move.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (timer_q == ONE_PER) begin
                    emit_s  = 1'b1;
                    rem_d   = rem_q - ONE_CNT;
                    timer_d = per_q;
                end else begin
                    timer_d = timer_q - ONE_PER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Phase, strobe and position update for an edge decided this cycle.
    always_comb begin
        phase_next_s = next_phase({a_q, b_q}, emit_fwd_s);
        if (emit_s) begin
            a_d    = phase_next_s[1];
            b_d    = phase_next_s[0];
            edge_d = 1'b1;
            if (emit_fwd_s) begin
                pos_d = pos_q + ONE_CNT;
            end else begin
                pos_d = pos_q - ONE_CNT;
            end
        end else begin
            a_d    = a_q;
            b_d    = b_q;
            edge_d = 1'b0;
            pos_d  = pos_q;
        end
    end

    // State and output registers; rst discards any move in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= ZERO_CNT;
            per_q   <= ONE_PER;
            timer_q <= ONE_PER;
            pos_q   <= ZERO_CNT;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            edge_q  <= 1'b0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            per_q   <= per_d;
            timer_q <= timer_d;
            pos_q   <= pos_d;
            a_q     <= a_d;
            b_q     <= b_d;
            edge_q  <= edge_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign A         = a_q;
    assign B         = b_q;
    assign edge_stb  = edge_q;
    assign direction = dir_q;
    assign done      = done_q;
    assign position  = pos_q;

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Scoreboard bench for quadrature_encoder_emulator: each accepted command
// expands into a list of expected edge/done events (cycle, {A,B}, position)
// computed from edge times k*period; a negedge monitor pops and compares.
module tb_quadrature_encoder_emulator;

    localparam int CNT_W = 32;
    localparam int PER_W = 16;

    typedef struct {
        bit         is_done;
        int         cyc;
        logic [1:0] ab;
        logic [31:0] pos;
    } ev_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    cmd_valid = 1'b0;
    logic                    abort = 1'b0;
    logic signed [CNT_W-1:0] cmd_steps = '0;
    logic        [PER_W-1:0] cmd_period = '0;
    logic                    cmd_ready, A, B, edge_stb, direction, busy, done;
    logic signed [CNT_W-1:0] position;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    ev_t         exp_q[$];
    int          mdl_idx = 0;
    logic [31:0] mdl_pos = '0;
    logic [1:0]  ab_tab[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0]  prev_ab = 2'b00;
    ev_t         mon_ev;

    quadrature_encoder_emulator #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_steps (cmd_steps),
        .cmd_period(cmd_period),
        .abort     (abort),
        .A         (A),
        .B         (B),
        .edge_stb  (edge_stb),
        .direction (direction),
        .busy      (busy),
        .done      (done),
        .position  (position)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every presented edge/done against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_ab = 2'b00;
        end else begin
            check("single_channel_change", {63'd0, (A != prev_ab[1]) && (B != prev_ab[0])}, 64'd0);
            check("stb_iff_change", {63'd0, edge_stb}, {63'd0, {A, B} != prev_ab});
            if (edge_stb) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_edge: got {A,B}=%b pos=%0d, required no edge (cycle %0d)",
                             {A, B}, position, cyc);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check("edge_kind", {63'd0, mon_ev.is_done}, 64'd0);
                    check("edge_cycle", 64'(cyc), 64'(mon_ev.cyc));
                    check("edge_ab", {62'd0, A, B}, {62'd0, mon_ev.ab});
                    check("edge_pos", {32'd0, position}, {32'd0, mon_ev.pos});
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, required 0 (cycle %0d)", cyc);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check("done_kind", {63'd0, mon_ev.is_done}, 64'd1);
                    check("done_cycle", 64'(cyc), 64'(mon_ev.cyc));
                end
            end
            prev_ab = {A, B};
        end
    end

    // Idle cycles with random abort pulses, which must have no effect in IDLE.
    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            cmd_valid = 1'b0;
            abort = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("idle_busy", {63'd0, busy}, 64'd0);
        end
        abort = 1'b0;
    endtask

    // Issue one command, expand it into expected events, and optionally run it to its end.
    // abort_rel: cycle after accept in which abort pulses (0 = never).
    task automatic run_move(input int steps, input int period, input int abort_rel, input bit wait_end);
        longint n, p, total, t;
        int     c, endc, guard;
        bit     run_abort, fwd;
        ev_t    ev;
        cmd_valid  = 1'b1;
        cmd_steps  = steps;
        cmd_period = period[15:0];
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 64) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cmd_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: cmd_ready=%b, required 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        c = cyc;
        n = (steps < 0) ? -longint'(steps) : longint'(steps);
        p = (period == 0) ? 1 : longint'(period);
        total = n * p;
        run_abort = (abort_rel >= 1) && (longint'(abort_rel) <= total);
        fwd = (steps >= 0);
        for (longint k = 1; k <= n; k++) begin
            t = longint'(c) + k * p;
            if (run_abort && t > longint'(c + abort_rel)) break;
            mdl_idx = fwd ? (mdl_idx + 1) % 4 : (mdl_idx + 3) % 4;
            mdl_pos = fwd ? mdl_pos + 32'd1 : mdl_pos - 32'd1;
            ev.is_done = 1'b0;
            ev.cyc = int'(t);
            ev.ab = ab_tab[mdl_idx];
            ev.pos = mdl_pos;
            exp_q.push_back(ev);
        end
        if (n == 0) endc = c + 1;
        else if (run_abort) endc = c + abort_rel + 1;
        else endc = int'(longint'(c) + total + 1);
        if (!run_abort) begin
            ev.is_done = 1'b1;
            ev.cyc = endc;
            ev.ab = ab_tab[mdl_idx];
            ev.pos = mdl_pos;
            exp_q.push_back(ev);
        end
        @(posedge clk);
        #1;
        abort = (cyc == c + abort_rel);
        cmd_valid = (n > 0 && cyc < endc) ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd_steps = $urandom;
        cmd_period = 16'($urandom);
        check("busy_after_accept", {63'd0, busy}, {63'd0, n != 0});
        check("ready_after_accept", {63'd0, cmd_ready}, {63'd0, n == 0});
        check("direction_latched", {63'd0, direction}, {63'd0, fwd});
        if (!wait_end) begin
            cmd_valid = 1'b0;
            abort = 1'b0;
            return;
        end
        while (cyc < endc) begin
            @(posedge clk);
            #1;
            abort = (cyc == c + abort_rel);
            cmd_valid = (cyc < endc) ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_steps = $urandom;
            cmd_period = 16'($urandom);
        end
        cmd_valid = 1'b0;
        check("end_position", {32'd0, position}, {32'd0, mdl_pos});
        check("end_ab", {62'd0, A, B}, {62'd0, ab_tab[mdl_idx]});
        check("end_busy", {63'd0, busy}, 64'd0);
        check("end_ready", {63'd0, cmd_ready}, 64'd1);
    endtask

    initial begin
        // Reset values, before any clock edge.
        #1;
        check("rst_A", {63'd0, A}, 64'd0);
        check("rst_B", {63'd0, B}, 64'd0);
        check("rst_edge_stb", {63'd0, edge_stb}, 64'd0);
        check("rst_direction", {63'd0, direction}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_position", {32'd0, position}, 64'd0);
        check("rst_ready", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases.
        run_move(4, 3, 0, 1'b1);
        idle(2);
        run_move(-3, 1, 0, 1'b1);
        idle(2);
        run_move(0, 5, 0, 1'b1);
        idle(2);
        run_move(10, 2, 6, 1'b1);
        idle(4);
        run_move(2, 1, 0, 1'b1);
        run_move(-2, 1, 0, 1'b1);
        idle(2);
        run_move(32'sh8000_0000, 1, 4, 1'b1);
        idle(3);
        run_move(3, 0, 0, 1'b1);
        idle(1);

        // Randomized moves, some chained on the done cycle, some aborted.
        for (int i = 0; i < 40; i++) begin
            int s, pp, nn, tot, ar;
            s = int'($urandom_range(0, 24)) - 12;
            pp = int'($urandom_range(0, 4));
            nn = (s < 0) ? -s : s;
            tot = nn * ((pp == 0) ? 1 : pp);
            ar = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, tot + 1)) : 0;
            run_move(s, pp, ar, 1'b1);
            idle(int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a long move.
        run_move(100, 2, 0, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_A", {63'd0, A}, 64'd0);
        check("midrst_B", {63'd0, B}, 64'd0);
        check("midrst_position", {32'd0, position}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_ready", {63'd0, cmd_ready}, 64'd1);
        check("midrst_direction", {63'd0, direction}, 64'd0);
        exp_q.delete();
        mdl_idx = 0;
        mdl_pos = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_move(5, 2, 0, 1'b1);
        idle(5);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
